// File: rtl/pipe_pkg.sv
// Shared types and bypass-select encodings for the F/D/X/M/W hazard controller.
package pipe_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    // Shadow rd storage is sized for the widest supported register file (RAW <= 8).
    localparam int RD_MAX = 8;
    typedef logic [RD_MAX-1:0] rd_t;

    typedef struct packed {
        logic valid;
        rd_t  rd;
        logic wen;
        logic load;
    } stage_t;

    function automatic logic stage_match(stage_t s, rd_t r, logic zero_reg);
        return s.valid & s.wen & (s.rd == r) & ~(zero_reg & (r == '0));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Core <-> hazard controller signal bundle; the controller sits on the slave side.
interface pipe_hazard_ctrl_if #(
    parameter int RAW = 5
);
    logic           f_valid;
    logic [RAW-1:0] d_rs1;
    logic [RAW-1:0] d_rs2;
    logic           d_use1;
    logic           d_use2;
    logic [RAW-1:0] d_rd;
    logic           d_wen;
    logic           d_load;
    logic           x_redirect;
    logic           m_wait;
    logic           stall_f;
    logic           stall_d;
    logic           kill_d;
    logic           bubble_x;
    logic           x_valid;
    logic           m_valid;
    logic           w_valid;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;
    logic           w_wen;

    modport master (
        output f_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_wen, d_load,
               x_redirect, m_wait,
        input  stall_f, stall_d, kill_d, bubble_x, x_valid, m_valid, w_valid,
               fwd_a, fwd_b, w_wen
    );

    modport slave (
        input  f_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_wen, d_load,
               x_redirect, m_wait,
        output stall_f, stall_d, kill_d, bubble_x, x_valid, m_valid, w_valid,
               fwd_a, fwd_b, w_wen
    );

endinterface

// File: rtl/stage_shadow.sv
// One pipeline-stage shadow register: hold keeps it, bubble loads din with valid cleared.
module stage_shadow
    import pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   bubble,
    input  stage_t din,
    output stage_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!hold) begin
            q <= '{valid: din.valid & ~bubble, rd: din.rd, wen: din.wen, load: din.load};
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/bypass controller for the 5-stage core: load-use stalls, redirect kills, dmem waits, X bypass.
// WB_BYPASS_EN enables the W->X bypass; without it a D read of an M writer stalls one cycle instead.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RAW       = 5,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit MEM_STALL = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    logic [1:0]     rst_sync;
    logic           rst_i_n;
    logic           d_valid;
    logic [RAW-1:0] x_rs1;
    logic [RAW-1:0] x_rs2;
    stage_t         d_s;
    stage_t         x_s;
    stage_t         m_s;
    stage_t         w_s;
    logic           mem_hold;
    logic           use_x;
    logic           load_use;
    logic           hazard;
    logic           stall_i;
    logic           kill_i;
    logic           bubble_i;
    logic [1:0]     fwd_a_i;
    logic [1:0]     fwd_b_i;
    logic           unused_w_load;

    // Reset asserts asynchronously and releases two edges later, clean of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    assign mem_hold = MEM_STALL && bus.m_wait;

    assign use_x = d_valid &
                   ((bus.d_use1 & stage_match(x_s, rd_t'(bus.d_rs1), ZERO_REG)) |
                    (bus.d_use2 & stage_match(x_s, rd_t'(bus.d_rs2), ZERO_REG)));
    assign load_use = use_x & x_s.load;

`ifdef WB_BYPASS_EN
    assign hazard = load_use;
`else
    // No W bypass: a reader of an M writer waits until the write-through regfile has the value.
    logic use_m;
    assign use_m = d_valid &
                   ((bus.d_use1 & stage_match(m_s, rd_t'(bus.d_rs1), ZERO_REG)) |
                    (bus.d_use2 & stage_match(m_s, rd_t'(bus.d_rs2), ZERO_REG)));
    assign hazard = load_use | use_m;
`endif

    always_comb begin
        stall_i  = 1'b0;
        kill_i   = 1'b0;
        bubble_i = 1'b0;
        if (mem_hold) begin
            stall_i = 1'b1;
        end else if (bus.x_redirect) begin
            // The dependent D instruction dies here, so any pending load-use is moot.
            kill_i   = 1'b1;
            bubble_i = 1'b1;
        end else if (hazard) begin
            stall_i  = 1'b1;
            bubble_i = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n)      d_valid <= 1'b0;
        else if (!stall_i) d_valid <= bus.f_valid & ~kill_i;
    end

    // Source addresses ride along with X even into a bubble; fwd_* is not gated by X.valid.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            x_rs1 <= '0;
            x_rs2 <= '0;
        end else if (!mem_hold) begin
            x_rs1 <= bus.d_rs1;
            x_rs2 <= bus.d_rs2;
        end
    end

    assign d_s = '{valid: d_valid, rd: rd_t'(bus.d_rd), wen: bus.d_wen, load: bus.d_load};

    stage_shadow u_x (.clk(clk), .rst_n(rst_i_n), .hold(mem_hold), .bubble(bubble_i),
                      .din(d_s), .q(x_s));
    stage_shadow u_m (.clk(clk), .rst_n(rst_i_n), .hold(mem_hold), .bubble(1'b0),
                      .din(x_s), .q(m_s));
    stage_shadow u_w (.clk(clk), .rst_n(rst_i_n), .hold(1'b0),     .bubble(mem_hold),
                      .din(m_s), .q(w_s));

    always_comb begin
        fwd_a_i = FWD_RF;
        fwd_b_i = FWD_RF;
        if (stage_match(m_s, rd_t'(x_rs1), ZERO_REG))      fwd_a_i = FWD_M;
`ifdef WB_BYPASS_EN
        else if (stage_match(w_s, rd_t'(x_rs1), ZERO_REG)) fwd_a_i = FWD_W;
`endif
        if (stage_match(m_s, rd_t'(x_rs2), ZERO_REG))      fwd_b_i = FWD_M;
`ifdef WB_BYPASS_EN
        else if (stage_match(w_s, rd_t'(x_rs2), ZERO_REG)) fwd_b_i = FWD_W;
`endif
    end

    assign unused_w_load = w_s.load;

    // Control outputs depend on raw inputs, so force them low while reset is held.
    assign bus.stall_f  = rst_i_n & stall_i;
    assign bus.stall_d  = rst_i_n & stall_i;
    assign bus.kill_d   = rst_i_n & kill_i;
    assign bus.bubble_x = rst_i_n & bubble_i;
    assign bus.x_valid  = x_s.valid;
    assign bus.m_valid  = m_s.valid;
    assign bus.w_valid  = w_s.valid;
    assign bus.fwd_a    = fwd_a_i;
    assign bus.fwd_b    = fwd_b_i;
    assign bus.w_wen    = w_s.valid & w_s.wen & (w_s.rd != '0);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one task per scenario, inline checks, summary at the end.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] C_NONE  = 4'b0000;  // {stall_f, stall_d, kill_d, bubble_x}
    localparam logic [3:0] C_STALL = 4'b1101;
    localparam logic [3:0] C_WAIT  = 4'b1100;
    localparam logic [3:0] C_REDIR = 4'b0011;

    pipe_hazard_ctrl_if #(.RAW(5)) bus ();

    pipe_hazard_ctrl #(.RAW(5), .ZERO_REG(1'b1), .MEM_STALL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] ctl();
        return {bus.stall_f, bus.stall_d, bus.kill_d, bus.bubble_x};
    endfunction

    function automatic logic [3:0] fwd();
        return {bus.fwd_a, bus.fwd_b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_instr(input int rs1, input int rs2, input int u1, input int u2,
                           input int rd, input int wen, input int ld);
        bus.d_rs1  = 5'(rs1);
        bus.d_rs2  = 5'(rs2);
        bus.d_use1 = (u1 != 0);
        bus.d_use2 = (u2 != 0);
        bus.d_rd   = 5'(rd);
        bus.d_wen  = (wen != 0);
        bus.d_load = (ld != 0);
    endtask

    task automatic flush();
        bus.m_wait     = 1'b0;
        bus.x_redirect = 1'b0;
        bus.f_valid    = 1'b1;
        d_instr(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.f_valid    = 1'b1;
        bus.m_wait     = 1'b1;
        bus.x_redirect = 1'b1;
        d_instr(5, 5, 1, 1, 5, 1, 1);
        repeat (2) tick();
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL rst_ctl got %b want %b", ctl(), C_NONE); end
        checks++; if ({bus.x_valid, bus.m_valid, bus.w_valid, bus.w_wen} !== 4'b0000) begin errors++;
            $display("FAIL rst_valid got %b want 0000", {bus.x_valid, bus.m_valid, bus.w_valid, bus.w_wen}); end
        checks++; if (fwd() !== 4'b0000) begin errors++; $display("FAIL rst_fwd got %b want 0000", fwd()); end
        bus.m_wait     = 1'b0;
        bus.x_redirect = 1'b0;
        d_instr(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) tick();
        checks++; if ({bus.x_valid, bus.m_valid, bus.w_valid} !== 3'b111) begin errors++;
            $display("FAIL rst_release_valid got %b want 111", {bus.x_valid, bus.m_valid, bus.w_valid}); end
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL rst_release_ctl got %b want %b", ctl(), C_NONE); end
    endtask

    // add x5,x1,x2 ; sub x6,x5,x1
    task automatic test_m_bypass();
        flush();
        d_instr(1, 2, 1, 1, 5, 1, 0);
        tick();
        d_instr(5, 1, 1, 1, 6, 1, 0); #1;
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL mbyp_ctl got %b want %b", ctl(), C_NONE); end
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd() !== 4'b0100) begin errors++; $display("FAIL mbyp_fwd got %b want 0100", fwd()); end
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL mbyp_ctl2 got %b want %b", ctl(), C_NONE); end
        tick();
        checks++; if ({bus.w_valid, bus.w_wen} !== 2'b11) begin errors++;
            $display("FAIL mbyp_wwen got %b want 11", {bus.w_valid, bus.w_wen}); end
    endtask

    // add x5 ; unrelated ; or x7,x5,x5
    task automatic test_w_distance();
        flush();
        d_instr(1, 2, 1, 1, 5, 1, 0);
        tick();
        d_instr(3, 4, 1, 1, 9, 1, 0);
        tick();
        d_instr(5, 5, 1, 1, 7, 1, 0); #1;
`ifdef WB_BYPASS_EN
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL wdist_ctl got %b want %b", ctl(), C_NONE); end
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd() !== 4'b1010) begin errors++; $display("FAIL wdist_fwd got %b want 1010", fwd()); end
`else
        checks++; if (ctl() !== C_STALL) begin errors++; $display("FAIL wdist_ctl got %b want %b", ctl(), C_STALL); end
        tick();
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL wdist_ctl2 got %b want %b", ctl(), C_NONE); end
        checks++; if (bus.x_valid !== 1'b0) begin errors++; $display("FAIL wdist_xbubble got %b want 0", bus.x_valid); end
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd() !== 4'b0000) begin errors++; $display("FAIL wdist_fwd got %b want 0000", fwd()); end
        checks++; if (bus.x_valid !== 1'b1) begin errors++; $display("FAIL wdist_xvalid got %b want 1", bus.x_valid); end
`endif
    endtask

    // lw x5 ; add x6,x5,x0
    task automatic test_load_use();
        flush();
        d_instr(2, 0, 1, 0, 5, 1, 1);
        tick();
        d_instr(5, 0, 1, 1, 6, 1, 0); #1;
        checks++; if (ctl() !== C_STALL) begin errors++; $display("FAIL lu_ctl got %b want %b", ctl(), C_STALL); end
        tick();
        checks++; if (bus.fwd_a !== 2'd1) begin errors++; $display("FAIL lu_fwd_a got %0d want 1", bus.fwd_a); end
        checks++; if (bus.x_valid !== 1'b0) begin errors++; $display("FAIL lu_xbubble got %b want 0", bus.x_valid); end
`ifdef WB_BYPASS_EN
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL lu_one_cycle got %b want %b", ctl(), C_NONE); end
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (bus.fwd_a !== 2'd2) begin errors++; $display("FAIL lu_fwd_w got %0d want 2", bus.fwd_a); end
`else
        checks++; if (ctl() !== C_STALL) begin errors++; $display("FAIL lu_mhaz got %b want %b", ctl(), C_STALL); end
        tick();
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL lu_release got %b want %b", ctl(), C_NONE); end
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (bus.fwd_a !== 2'd0) begin errors++; $display("FAIL lu_fwd_rf got %0d want 0", bus.fwd_a); end
`endif
    endtask

    // Redirect in X while the D instruction depends on a load in X
    task automatic test_redirect();
        flush();
        d_instr(2, 0, 1, 0, 5, 1, 1);
        tick();
        d_instr(5, 0, 1, 1, 6, 1, 0);
        bus.x_redirect = 1'b1; #1;
        checks++; if (ctl() !== C_REDIR) begin errors++; $display("FAIL redir_ctl got %b want %b", ctl(), C_REDIR); end
        tick();
        bus.x_redirect = 1'b0; #1;
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL redir_nostall got %b want %b", ctl(), C_NONE); end
        checks++; if (bus.x_valid !== 1'b0) begin errors++; $display("FAIL redir_xbubble got %b want 0", bus.x_valid); end
        tick();
        checks++; if (bus.x_valid !== 1'b0) begin errors++; $display("FAIL redir_killed got %b want 0", bus.x_valid); end
    endtask

    // add x5 in M while dmem waits three cycles
    task automatic test_mem_wait();
        flush();
        d_instr(1, 2, 1, 1, 5, 1, 0);
        tick();
        d_instr(5, 1, 1, 1, 6, 1, 0);
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0);
        bus.m_wait = 1'b1; #1;
        checks++; if (ctl() !== C_WAIT) begin errors++; $display("FAIL wait0_ctl got %b want %b", ctl(), C_WAIT); end
        checks++; if (fwd() !== 4'b0100) begin errors++; $display("FAIL wait0_fwd got %b want 0100", fwd()); end
        for (int i = 1; i < 3; i++) begin
            tick();
            bus.x_redirect = (i == 1); #1;
            checks++; if (ctl() !== C_WAIT) begin errors++; $display("FAIL wait%0d_ctl got %b want %b", i, ctl(), C_WAIT); end
            checks++; if (fwd() !== 4'b0100) begin errors++; $display("FAIL wait%0d_fwd got %b want 0100", i, fwd()); end
            checks++; if ({bus.m_valid, bus.w_valid} !== 2'b10) begin errors++;
                $display("FAIL wait%0d_mw got %b want 10", i, {bus.m_valid, bus.w_valid}); end
        end
        tick();
        bus.m_wait     = 1'b0;
        bus.x_redirect = 1'b0; #1;
        checks++; if ({ctl(), bus.w_valid} !== 5'b00000) begin errors++;
            $display("FAIL wait_drop got %b want 00000", {ctl(), bus.w_valid}); end
        checks++; if (bus.fwd_a !== 2'd1) begin errors++; $display("FAIL wait_drop_fwd got %0d want 1", bus.fwd_a); end
        tick();
        checks++; if ({bus.w_valid, bus.w_wen} !== 2'b11) begin errors++;
            $display("FAIL wait_retire got %b want 11", {bus.w_valid, bus.w_wen}); end
    endtask

    // lw x0 then a reader of x0, followed by a reset in the middle of traffic
    task automatic test_zero_reg_and_reset();
        flush();
        d_instr(1, 0, 1, 0, 0, 1, 1);
        tick();
        d_instr(0, 0, 1, 1, 8, 1, 0); #1;
        checks++; if (ctl() !== C_NONE) begin errors++; $display("FAIL x0_ctl got %b want %b", ctl(), C_NONE); end
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd() !== 4'b0000) begin errors++; $display("FAIL x0_fwd got %b want 0000", fwd()); end
        tick();
        checks++; if ({bus.w_valid, bus.w_wen} !== 2'b10) begin errors++;
            $display("FAIL x0_wwen got %b want 10", {bus.w_valid, bus.w_wen}); end
        d_instr(1, 2, 1, 1, 5, 1, 0);
        tick();
        d_instr(5, 1, 1, 1, 6, 1, 0);
        tick();
        d_instr(0, 0, 0, 0, 0, 0, 0);
        bus.m_wait     = 1'b1;
        bus.x_redirect = 1'b1; #1;
        checks++; if ({ctl(), bus.fwd_a} !== {C_WAIT, 2'd1}) begin errors++;
            $display("FAIL prerst got %b want %b", {ctl(), bus.fwd_a}, {C_WAIT, 2'd1}); end
        rst_n = 1'b0; #1;
        checks++; if ({ctl(), fwd()} !== 8'h00) begin errors++; $display("FAIL midrst_ctl got %b want 0", {ctl(), fwd()}); end
        checks++; if ({bus.x_valid, bus.m_valid, bus.w_valid, bus.w_wen} !== 4'b0000) begin errors++;
            $display("FAIL midrst_valid got %b want 0000", {bus.x_valid, bus.m_valid, bus.w_valid, bus.w_wen}); end
        bus.m_wait     = 1'b0;
        bus.x_redirect = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_m_bypass();
        test_w_distance();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_zero_reg_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
